// File: rtl/dmem_burst_responder.sv
// Data memory with a single-word user port and an 8-beat line-fill/writeback
// burst responder for the data cache.
module dmem_burst_responder #(
  parameter int ADDR_W     = 13,
  parameter int DEPTH      = 8192,
  parameter int LINE_WORDS = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic              user_we,
  input  logic [31:0]       user_din,
  output logic [31:0]       user_dout,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-4:0] mem_line,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_wready,
  output logic              mem_rvalid,
  output logic [31:0]       mem_rdata,
  output logic              mem_done
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);
  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  logic [31:0]       r_mem [DEPTH];
  state_t            r_state;
  logic [ADDR_W-4:0] r_line;
  logic              r_we;
  logic [2:0]        r_beat;
  logic [3:0]        r_cnt;
  logic              r_ack;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic [31:0]       r_udout;
  logic [ADDR_W-1:0] w_baddr;
  logic              w_bwr;

  // Beat address stays inside the latched line; the 3-bit counter wraps.
  assign w_baddr = {r_line, r_beat};
  assign w_bwr   = (r_state == S_BURST) && r_we;

  // Array has no reset. Burst write is assigned last so it wins a collision.
  always_ff @(posedge clk) begin
    if (user_we) r_mem[user_addr] <= user_din;
    if (w_bwr)   r_mem[w_baddr]   <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_line   <= '0;
      r_we     <= 1'b0;
      r_beat   <= 3'd0;
      r_cnt    <= 4'd0;
      r_ack    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_udout  <= 32'd0;
    end else begin
      r_udout  <= r_mem[user_addr];
      r_ack    <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_line  <= mem_line;
            r_we    <= mem_we;
            r_cnt   <= LAT_M1;
            r_beat  <= 3'd0;
            r_ack   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_BURST;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_BURST: begin
          if (!r_we) begin
            r_rdata  <= r_mem[w_baddr];
            r_rvalid <= 1'b1;
          end
          r_beat <= r_beat + 3'd1;
          if (r_beat == LAST_BEAT) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign user_dout  = r_udout;
  assign mem_ack    = r_ack;
  assign mem_busy   = (r_state != S_IDLE);
  assign mem_wready = w_bwr;
  assign mem_rvalid = r_rvalid;
  assign mem_rdata  = r_rdata;
  assign mem_done   = (r_state == S_DONE);
endmodule

// File: tb/tb_dmem_burst_responder.sv
// Directed bench for dmem_burst_responder: user port, fill, writeback,
// back-to-back requests, write collision and mid-burst reset.
module tb_dmem_burst_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] user_addr;
  logic        user_we;
  logic [31:0] user_din;
  logic [31:0] user_dout;
  logic        mem_req, mem_we;
  logic [9:0]  mem_line;
  logic [31:0] mem_wdata;
  logic        mem_ack, mem_busy, mem_wready, mem_rvalid, mem_done;
  logic [31:0] mem_rdata;

  int npass = 0;
  int nchk  = 0;

  dmem_burst_responder #(.ADDR_W(13), .DEPTH(8192), .LINE_WORDS(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .user_addr(user_addr), .user_we(user_we), .user_din(user_din), .user_dout(user_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_line(mem_line), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_busy(mem_busy), .mem_wready(mem_wready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic dump(input int a, input logic [31:0] exp, input string tag);
    user_addr = 13'(a);
    tick();
    chk(tag, user_dout, exp);
  endtask

  initial begin
    rst = 1'b1; user_addr = '0; user_we = 1'b0; user_din = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_line = '0; mem_wdata = '0;
    #1;
    chk("rst_ack",    32'(mem_ack), 32'd0);
    chk("rst_busy",   32'(mem_busy), 32'd0);
    chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
    chk("rst_dout",   user_dout, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // preload words 0..19 with 1..20
    for (int i = 0; i < 20; i++) begin
      user_we = 1'b1; user_addr = 13'(i); user_din = 32'(i + 1);
      tick();
    end
    user_we = 1'b0;
    dump(5, 32'd6, "user_rd5");
    user_addr = 13'd3; user_we = 1'b1; user_din = 32'd99;
    tick();
    chk("rbw_old", user_dout, 32'd4);
    user_we = 1'b0;
    tick();
    chk("rbw_new", user_dout, 32'd99);

    // line fill of line 1 (words 8..15 hold 9..16)
    mem_req = 1'b1; mem_we = 1'b0; mem_line = 10'd1;
    tick();
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("fill_ack_c%0d", c),  32'(mem_ack),    32'(c == 1));
      chk($sformatf("fill_busy_c%0d", c), 32'(mem_busy),   32'(c <= 13));
      chk($sformatf("fill_rv_c%0d", c),   32'(mem_rvalid), 32'(c >= 6 && c <= 13));
      chk($sformatf("fill_done_c%0d", c), 32'(mem_done),   32'(c == 13));
      chk($sformatf("fill_wr_c%0d", c),   32'(mem_wready), 32'd0);
      if (c >= 6 && c <= 13) chk($sformatf("fill_data_c%0d", c), mem_rdata, 32'(c + 3));
      if (c == 1) begin mem_req = 1'b0; mem_line = 10'd7; end
      tick();
    end

    // writeback of line 2 with 0xA0+beat
    mem_req = 1'b1; mem_we = 1'b1; mem_line = 10'd2;
    tick();
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin mem_req = 1'b0; mem_we = 1'b0; end
      mem_wdata = (c >= 5 && c <= 12) ? 32'(32'hA0 + c - 5) : 32'hFFFF_FFFF;
      chk($sformatf("wb_ack_c%0d", c),  32'(mem_ack),    32'(c == 1));
      chk($sformatf("wb_wr_c%0d", c),   32'(mem_wready), 32'(c >= 5 && c <= 12));
      chk($sformatf("wb_done_c%0d", c), 32'(mem_done),   32'(c == 13));
      chk($sformatf("wb_rv_c%0d", c),   32'(mem_rvalid), 32'd0);
      tick();
    end
    for (int i = 0; i < 8; i++) dump(16 + i, 32'(32'hA0 + i), $sformatf("wb_dump%0d", i));

    // back-to-back fills of line 1 with mem_req held high
    mem_req = 1'b1; mem_we = 1'b0; mem_line = 10'd1;
    tick();
    for (int c = 1; c <= 28; c++) begin
      chk($sformatf("b2b_ack_c%0d", c),  32'(mem_ack),  32'(c == 1 || c == 15));
      chk($sformatf("b2b_busy_c%0d", c), 32'(mem_busy), 32'(c != 14 && c != 28));
      chk($sformatf("b2b_rv_c%0d", c),   32'(mem_rvalid),
          32'((c >= 6 && c <= 13) || (c >= 20 && c <= 27)));
      if (c >= 20 && c <= 27) chk($sformatf("b2b_data_c%0d", c), mem_rdata, 32'(c - 11));
      if (c == 15) mem_req = 1'b0;
      tick();
    end

    // writeback of line 0 colliding with a user write at beat 2
    mem_req = 1'b1; mem_we = 1'b1; mem_line = 10'd0;
    tick();
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) mem_req = 1'b0;
      mem_wdata = 32'(32'hB0 + c - 5);
      user_we   = (c == 7);
      user_addr = 13'd2; user_din = 32'hDEAD;
      tick();
    end
    user_we = 1'b0;
    for (int i = 0; i < 8; i++) dump(i, 32'(32'hB0 + i), $sformatf("col_dump%0d", i));

    // reset after three writeback beats of line 0
    mem_req = 1'b1; mem_we = 1'b1; mem_line = 10'd0;
    tick();
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) mem_req = 1'b0;
      mem_wdata = 32'(32'hC0 + c - 5);
      tick();
    end
    chk("pre_rst_wready", 32'(mem_wready), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(mem_busy),   32'd0);
    chk("mid_rst_wready", 32'(mem_wready), 32'd0);
    chk("mid_rst_done",   32'(mem_done),   32'd0);
    chk("mid_rst_ack",    32'(mem_ack),    32'd0);
    chk("mid_rst_rdata",  mem_rdata,       32'd0);
    chk("mid_rst_dout",   user_dout,       32'd0);
    tick();
    rst = 1'b0; mem_we = 1'b0;
    for (int i = 0; i < 8; i++)
      dump(i, (i < 3) ? 32'(32'hC0 + i) : 32'(32'hB0 + i), $sformatf("rst_dump%0d", i));

    // normal fill of line 0 after the aborted burst
    mem_req = 1'b1; mem_we = 1'b0; mem_line = 10'd0;
    tick();
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin
        chk("post_rst_ack", 32'(mem_ack), 32'd1);
        mem_req = 1'b0;
      end
      chk($sformatf("post_rv_c%0d", c), 32'(mem_rvalid), 32'(c >= 6 && c <= 13));
      if (c >= 6 && c <= 13)
        chk($sformatf("post_data_c%0d", c), mem_rdata,
            (c < 9) ? 32'(32'hC0 + c - 6) : 32'(32'hB0 + c - 6));
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/dmem_burst_responder.md
Name: dmem_burst_responder

Overview:
- Main data memory behind the PipelineMIPS data cache; the responder end of the cache line-fill/writeback protocol.
- Holds DEPTH 32-bit words.
- Serves 8-word line bursts to the cache after a programmable latency.
- Also exposes the always-available single-word user port (user_addr/user_we/user_din/user_dout) that benches use to preload and dump memory.

Parameters:
- ADDR_W, 13, word-address width (word address = byte address [14:2]).
- DEPTH, 8192, number of words (2**ADDR_W).
- LINE_WORDS, 8, words per cache line; fixed at 8 (3-bit beat counter).
- LATENCY, 4, wait cycles between request acceptance and first beat; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- user_addr  in  13  user-port word address.
- user_we  in  1  user-port write enable.
- user_din  in  32  user-port write data.
- user_dout  out  32  user-port registered read data.
- mem_req  in  1  cache burst request; held by cache until mem_ack.
- mem_we  in  1  1 = writeback burst, 0 = line fill; sampled with mem_req.
- mem_line  in  10  line address (word address [12:3]); sampled with mem_req.
- mem_wdata  in  32  writeback beat data; consumed when mem_wready=1.
- mem_ack  out  1  one-cycle pulse: request accepted.
- mem_busy  out  1  high whenever state != IDLE.
- mem_wready  out  1  writeback beat consumed this cycle.
- mem_rvalid  out  1  fill beat valid on mem_rdata.
- mem_rdata  out  32  fill beat data, registered.
- mem_done  out  1  one-cycle pulse: burst complete.

Behaviour:
- Reset (async, any time):
  - All outputs 0; state IDLE; beat counter 0; latency counter 0.
  - Memory array is NOT cleared.
  - Reset mid-burst aborts it; beats already written remain in memory.
- User port (independent of the FSM, never stalls):
  - Every edge: user_dout <= mem[user_addr].
  - If user_we, mem[user_addr] <= user_din.
  - Read-before-write: same-address read in a write cycle returns the old word.
- FSM states: IDLE, WAIT, BURST, DONE.
  - IDLE:
    - On an edge with mem_req=1: latch mem_line and mem_we; load latency counter with LATENCY-1; beat=0.
    - Go to WAIT; mem_ack=1 for the following cycle only.
  - WAIT: counter decrements each edge; transition to BURST on the edge where the counter is 0. Duration is exactly LATENCY cycles.
  - BURST, write (mem_we latched 1):
    - mem_wready=1 every BURST cycle.
    - At each edge, mem[{line,beat}] <= mem_wdata; beat++.
    - After beat 7, go to DONE.
  - BURST, read:
    - Each edge registers mem[{line,beat}] into mem_rdata with mem_rvalid=1 the next cycle; beat++.
    - After beat 7, go to DONE.
    - mem_rvalid is high for 8 consecutive cycles; the last one coincides with the DONE cycle.
  - DONE: mem_done=1 for one cycle, then IDLE. A new mem_req is accepted on the edge leaving IDLE, earliest one cycle after DONE.
- Timing, request sampled at edge 0:
  - mem_ack in cycle 1.
  - WAIT spans cycles 1..LATENCY.
  - Beats in cycles LATENCY+1..LATENCY+8.
  - mem_done in cycle LATENCY+9.
  - Read data valid cycles LATENCY+2..LATENCY+9.
- Beat addressing: word address {line, beat}; beat wraps 7->0 within the line and never crosses the line.
- mem_req while busy is ignored. mem_req/mem_we/mem_line changes after acceptance are ignored.
- Collisions:
  - User write and burst write to the same word in the same cycle: burst data is stored.
  - User read of a word being burst-written returns the old value.
  - Burst read of a word being user-written returns the old value.

Test Plan:
- Preload via user port: write 1..20 to words 0..19, then read word 5 → user_dout=6 one cycle after address applied. Same-cycle write/read of word 3 with din=99 → old value 4, then 99 next cycle.
- Line fill, LATENCY=4, line 1 (words 8..15 preloaded 9..16), req at edge 0 → mem_ack cycle 1; mem_rvalid cycles 6..13 with data 9..16; mem_done cycle 13; mem_busy cycles 1..13.
- Writeback line 2, mem_wdata = 0xA0+beat → mem_wready cycles 5..12; user dump of words 16..23 returns 0xA0..0xA7; mem_done cycle 13.
- Back-to-back: mem_req held high continuously → second mem_ack in cycle 15 (done 13, IDLE 14, accept at edge 14); no beats overlap.
- Collision: during writeback of line 0, user_we to word 2 with 0xDEAD in the same cycle as beat 2 → word 2 holds the burst data.
- Reset mid-burst after 3 write beats → all outputs 0 immediately. Words 0..2 updated, 3..7 unchanged. Next req served normally with ack in cycle 1.
